// File: rtl/div_sequencer_if.sv
// div_sequencer_if: start/ready handshake and operand/result bus between the
// hazard unit (master) and the EX-stage divide sequencer (slave).
//
// Handshake: the master raises start (level) and holds it, together with
// stable signed_div/opdata1/opdata2, until it sees ready=1; operands are only
// sampled on the cycle the sequencer accepts. ready=1 marks result valid and
// stays high while start stays high; dropping start releases the unit, which
// clears ready and result on the following cycle. annul aborts any operation
// in flight and discards its result.
interface div_sequencer_if #(
  parameter int DATA_W = 32
);
  logic                  start;
  logic                  signed_div;
  logic [DATA_W-1:0]     opdata1;
  logic [DATA_W-1:0]     opdata2;
  logic                  annul;
  logic [2*DATA_W-1:0]   result;
  logic                  ready;

  modport master (
    output start, signed_div, opdata1, opdata2, annul,
    input  result, ready
  );

  modport slave (
    input  start, signed_div, opdata1, opdata2, annul,
    output result, ready
  );
endinterface

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle signed/unsigned divide for the EX stage.
// Radix-2 restoring shift-subtract on operand magnitudes, one quotient bit per
// cycle, with sign fix-up in a final cycle. Result is {remainder, quotient}.
// Optional macro DIV_EARLY_OUT_EN: when |dividend| < |divisor| the answer is
// known at accept time (quotient 0, remainder = dividend) and the iterative
// phase is skipped.
module div_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  div_sequencer_if.slave     bus,
  output logic [1:0]         dbg_state_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;      // partial remainder
  logic [DATA_W-1:0]   quo_q, quo_d;      // dividend shifting out, quotient shifting in
  logic [DATA_W-1:0]   dvs_q, dvs_d;      // divisor magnitude
  logic                sign1_q, sign1_d;  // original dividend sign
  logic                sign2_q, sign2_d;  // original divisor sign
  logic                sgn_q, sgn_d;      // operation is signed
  logic                ready_q, ready_d;
  logic [2*DATA_W-1:0] result_q, result_d;

  // Operand magnitudes; only meaningful on the accept cycle.
  logic [DATA_W-1:0]   op1_abs, op2_abs;
  // One restoring step: the shifted remainder needs one extra bit because the
  // divisor magnitude may exceed 2^(DATA_W-1).
  logic [DATA_W:0]     rem_sh;
  logic                no_borrow;
  // Sign-corrected final values.
  logic [DATA_W-1:0]   quo_fin, rem_fin;

  assign op1_abs = (bus.signed_div && bus.opdata1[DATA_W-1]) ? (DATA_W'(0) - bus.opdata1) : bus.opdata1;
  assign op2_abs = (bus.signed_div && bus.opdata2[DATA_W-1]) ? (DATA_W'(0) - bus.opdata2) : bus.opdata2;
  assign rem_sh    = {rem_q, quo_q[DATA_W-1]};
  assign no_borrow = (rem_sh >= {1'b0, dvs_q});
  assign quo_fin   = (sgn_q && (sign1_q ^ sign2_q)) ? (DATA_W'(0) - quo_q) : quo_q;
  assign rem_fin   = (sgn_q && sign1_q) ? (DATA_W'(0) - rem_q) : rem_q;

  assign bus.ready   = ready_q;
  assign bus.result  = result_q;
  assign dbg_state_o = state_q;

  // State and datapath registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      sgn_q    <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      sgn_q    <= sgn_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  // Next-state, datapath step and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    sgn_d    = sgn_q;
    ready_d  = ready_q;
    result_d = result_q;

    case (state_q)
      S_FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (bus.start && !bus.annul) begin
          if (bus.opdata2 == '0) begin
            state_d = S_BYZERO;
          end else begin
            rem_d   = '0;
            quo_d   = op1_abs;
            dvs_d   = op2_abs;
            sign1_d = bus.opdata1[DATA_W-1];
            sign2_d = bus.opdata2[DATA_W-1];
            sgn_d   = bus.signed_div;
            cnt_d   = '0;
            state_d = S_ON;
`ifdef DIV_EARLY_OUT_EN
            // Quotient is trivially zero; remainder is the dividend as given.
            if (op1_abs < op2_abs) begin
              state_d  = S_END;
              ready_d  = 1'b1;
              result_d = {bus.opdata1, {DATA_W{1'b0}}};
            end
`endif
          end
        end
      end

      S_BYZERO: begin
        state_d  = S_END;
        ready_d  = 1'b1;
        result_d = '0;
      end

      S_ON: begin
        if (cnt_q < CNT_LAST) begin
          if (no_borrow) begin
            rem_d = rem_sh[DATA_W-1:0] - dvs_q;
            quo_d = {quo_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[DATA_W-1:0];
            quo_d = {quo_q[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
        end else begin
          result_d = {rem_fin, quo_fin};
          ready_d  = 1'b1;
          state_d  = S_END;
        end
      end

      S_END: begin
        if (!bus.start) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end

      default: begin
        state_d  = S_FREE;
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase

    // A flush discards whatever is in flight, including a finished result.
    if (bus.annul && (state_q != S_FREE)) begin
      state_d  = S_FREE;
      ready_d  = 1'b0;
      result_d = '0;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed self-checking bench for div_sequencer.
// Inputs are driven and outputs sampled on the falling edge; cycle k of an
// operation is the clock period following the k-th rising edge after the
// accept cycle (cycle 0).
module tb_div_sequencer;

  localparam int DATA_W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 34;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  int checks;
  int failures;

  div_sequencer_if #(.DATA_W(DATA_W)) bus ();

  div_sequencer #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison point.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive an operation in cycle 0, hold start and wait (bounded) for ready.
  task automatic run_op(input logic sd, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    bus.start      = 1'b1;
    bus.signed_div = sd;
    bus.opdata1    = a;
    bus.opdata2    = b;
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      // Operands are free to change once accepted.
      bus.opdata1 = $urandom;
      bus.opdata2 = $urandom;
      if (bus.ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) check("ready_timeout", 64'd1, 64'd0);
  endtask

  // Drop start and check the unit releases on the next cycle.
  task automatic release_op(input string tag);
    bus.start = 1'b0;
    @(negedge clk);
    check({tag, "_rel_ready"}, {63'd0, bus.ready}, 64'd0);
    check({tag, "_rel_result"}, bus.result, 64'd0);
    check({tag, "_rel_state"}, {62'd0, dbg_state}, 64'd0);
  endtask

  // Directed sequence.
  initial begin
    int lat;
    logic seen_ready;
    logic [63:0] held;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1 = '0;
    bus.opdata2 = '0;
    bus.annul = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, bus.ready}, 64'd0);
    check("rst_result", bus.result, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1. DIVU 100/7.
    run_op(1'b0, 32'd100, 32'd7, lat);
    check("divu_100_7_lat", 64'(lat), 64'd34);
    check("divu_100_7_res", bus.result, 64'h00000002_0000000E);
    release_op("divu_100_7");

    // 2. Signed -7/2 and 7/-2.
    run_op(1'b1, 32'hFFFFFFF9, 32'h00000002, lat);
    check("div_m7_2_lat", 64'(lat), 64'd34);
    check("div_m7_2_res", bus.result, 64'hFFFFFFFF_FFFFFFFD);
    release_op("div_m7_2");
    run_op(1'b1, 32'h00000007, 32'hFFFFFFFE, lat);
    check("div_7_m2_res", bus.result, 64'h00000001_FFFFFFFD);
    release_op("div_7_m2");

    // Same bit pattern as unsigned, and a divisor above 2^31.
    run_op(1'b0, 32'hFFFFFFF9, 32'h00000002, lat);
    check("divu_fff9_2_res", bus.result, 64'h00000001_7FFFFFFC);
    release_op("divu_fff9_2");
    run_op(1'b0, 32'hFFFFFFFF, 32'h80000001, lat);
    check("divu_big_dvs_res", bus.result, 64'h7FFFFFFE_00000001);
    release_op("divu_big_dvs");

    // 3. Divide by zero and signed overflow.
    run_op(1'b0, 32'h12345678, 32'h0, lat);
    check("divz_lat", 64'(lat), 64'd2);
    check("divz_res", bus.result, 64'h0);
    release_op("divz");
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, lat);
    check("ovf_lat", 64'(lat), 64'd34);
    check("ovf_res", bus.result, 64'h00000000_80000000);
    release_op("ovf");

    // annul together with start in FREE: no accept.
    bus.start = 1'b1;
    bus.annul = 1'b1;
    bus.opdata1 = 32'd9;
    bus.opdata2 = 32'd3;
    @(negedge clk);
    check("annul_start_free_state", {62'd0, dbg_state}, 64'd0);
    bus.start = 1'b0;
    bus.annul = 1'b0;
    @(negedge clk);

    // 4. Flush in cycle 10.
    bus.start = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1 = 32'd1000;
    bus.opdata2 = 32'd3;
    seen_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) seen_ready = 1'b1;
    end
    check("flush_on_state", {62'd0, dbg_state}, 64'd2);
    bus.annul = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.annul = 1'b0;
    check("flush_state", {62'd0, dbg_state}, 64'd0);
    check("flush_result", bus.result, 64'd0);
    for (int k = 0; k < 30; k++) begin
      if (bus.ready === 1'b1) seen_ready = 1'b1;
      @(negedge clk);
    end
    check("flush_no_ready", {63'd0, seen_ready}, 64'd0);
    run_op(1'b0, 32'd9, 32'd3, lat);
    check("post_flush_lat", 64'(lat), 64'd34);
    check("post_flush_res", bus.result, 64'h00000000_00000003);

    // 5. END hold with start high, then release.
    held = bus.result;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_ready", {63'd0, bus.ready}, 64'd1);
      check("hold_result", bus.result, 64'h00000000_00000003);
    end
    check("hold_state", {62'd0, dbg_state}, 64'd3);
    release_op("hold");

    // Reset during ON.
    bus.start = 1'b1;
    bus.opdata1 = 32'd500;
    bus.opdata2 = 32'd6;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_on_ready", {63'd0, bus.ready}, 64'd0);
    check("rst_on_result", bus.result, 64'd0);
    check("rst_on_state", {62'd0, dbg_state}, 64'd0);
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // 6. Early-out candidate DIVU 5/9 and signed -3/7.
    run_op(1'b0, 32'd5, 32'd9, lat);
    check("early_lat", 64'(lat), 64'(EARLY_LAT));
    check("early_res", bus.result, 64'h00000005_00000000);
    release_op("early");
    run_op(1'b1, 32'hFFFFFFFD, 32'd7, lat);
    check("early_neg_lat", 64'(lat), 64'(EARLY_LAT));
    check("early_neg_res", bus.result, 64'hFFFFFFFD_00000000);
    release_op("early_neg");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
